pwm_multi: RTL and testbench
============================

# pwm_multi

Multi-channel, double-buffered PWM generator: the generalised successor of the single-channel fixed-period PWM. N_CH channels share one programmable period counter. Each channel has its own duty, polarity and enable. Configuration is written to shadow registers and applied atomically at a period boundary, so outputs never glitch mid-period. Sits between the CSR/bus interface and LED/motor/pmod pins, and also provides a period-sync pulse for ADC or sequencer triggering.

## Interface
- WIDTH, 10, bit width of the period counter, period and duty values
- N_CH, 4, number of PWM channels (1..16)
- clk  in  1  single clock for the whole block
- rst  in  1  reset; synchronous, active-high
- cfg_period  in  WIDTH  period value P; the period lasts P+1 clk cycles
- cfg_duty  in  N_CH*WIDTH  duty D per channel; channel i uses bits [i*WIDTH +: WIDTH]
- cfg_inv  in  N_CH  per-channel output inversion
- cfg_en  in  N_CH  per-channel enable
- cfg_stb  in  1  one-cycle strobe; captures all cfg_* inputs into the shadow registers
- cfg_pend  out  1  shadow holds values not yet applied
- upd_done  out  1  one-cycle pulse when shadow values become active
- sync  out  1  one-cycle pulse marking the first cycle of each period on pwm
- pwm  out  N_CH  PWM outputs

## Operation
- Counter `cnt` (WIDTH bits) counts 0..P_a, where P_a is the active period. When cnt==P_a (the wrap cycle), it returns to 0.
- Active set: P_a, D_a[i], inv_a[i], en_a[i]. It is loaded only in the wrap cycle, and only when `pend` is set.
- Shadow set: loaded whenever cfg_stb=1. This sets `pend`. A later strobe before the wrap overwrites the shadow; last write wins.
- Wrap cycle with pend=1 and cfg_stb=0: active <= shadow, pend <= 0, upd_done <= 1.
- Wrap cycle with pend=1 and cfg_stb=1: active <= the old shadow. The shadow captures the new values. pend stays 1. upd_done <= 1. The new values apply at the next wrap.
- Wrap cycle with pend=0 and cfg_stb=1: the active set is unchanged. The shadow captures the values and pend <= 1.
- Channel output (registered): pwm[i] <= en_a[i] ? ((cnt < D_a[i]) ^ inv_a[i]) : 1'b0.
  - A disabled channel drives 0 regardless of inv.
- Duty arithmetic is an unsigned WIDTH-bit compare.
  - D=0 gives constant low.
  - D>=P+1 (including D>P) saturates to constant high.
  - Otherwise the output is high for exactly D cycles of every P+1.
- P=0 means a 1-cycle period. Every cycle is a wrap cycle, so a pending update applies on the next edge.
- sync <= (cnt==0), registered.
- Reset forces the following:
  - cnt=0; all active and shadow fields = 0.
  - pend=0, cfg_pend=0, upd_done=0, sync=0, pwm=0.
  - Reset mid-period discards pending shadow values; there is no partial update.
- cfg_pend = pend, driven directly from the register.

## Timing
- pwm and sync have one cycle of latency from cnt. sync is high in the same cycle that pwm first reflects cnt==0, so sync coincides with the rising edge of every enabled non-inverted channel with D>0.
- Strobe-to-effect latency depends on the strobe position. With cfg_stb in a non-wrap cycle at count c, the update applies at the edge ending cycle cnt==P_a. The first pwm cycle using the new values is (P_a - c) + 2 cycles after the strobe cycle.
- upd_done is asserted in the cycle where cnt==0 with the new active set. This is one cycle before sync for that period.
- cfg_pend rises the cycle after cfg_stb. It falls in the same cycle as upd_done, unless the strobe coincided with the wrap.
- All channels switch configuration on the same edge. No output ever has a truncated or doubled period due to an update.
- After reset release, the first cfg_stb applies at the next edge: with P_a=0, every cycle is a wrap.

## Test plan
- Reset, then strobe P=9, D0=3, D1=7, en=2'b11, inv=0 (WIDTH=8, N_CH=2). Required response:
  - upd_done 1 cycle after the strobe.
  - Then repeating 10-cycle periods: pwm[0] high 3 cycles, pwm[1] high 7 cycles.
  - sync high on the first high cycle of both.
- Boundary duties with P=9. Required response:
  - D=0 gives a constant 0.
  - D=10 and D=255 give a constant 1.
  - inv=1 with D=0 gives a constant 1.
  - en=0 with inv=1 gives a constant 0.
- Mid-period update: at cnt=4, strobe D0=5. Required response:
  - pwm[0] keeps 3-cycle pulses for the rest of the current period.
  - cfg_pend is high until the wrap.
  - The next period has a 5-cycle pulse.
- Collision: strobe A in the middle of the period, then strobe B exactly in the wrap cycle. Required response:
  - A applies at this wrap, with upd_done pulsed and cfg_pend staying 1.
  - B applies one period later, with a second upd_done.
- Period change 9→3 with D0=2. Required response: the current 10-cycle period completes intact, then periods of 4 cycles with 2 high, and sync every 4 cycles.
- Assert rst mid-period with an update pending. Required response:
  - All outputs are 0 the cycle after rst.
  - cfg_pend=0, and the pending values are never applied.
  - A new strobe after reset applies on the next edge.

Source files
------------

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel, double-buffered PWM generator.
// N_CH channels share one programmable period counter. Configuration is
// captured into a shadow set on cfg_stb and copied into the active set
// only at a period wrap, so every channel switches on the same edge and
// no period is ever truncated or doubled.
//
// Ports
//   clk        single clock
//   rst        synchronous, active-high reset
//   cfg_period period value P (period lasts P+1 cycles)
//   cfg_duty   per-channel duty, channel i at [i*WIDTH +: WIDTH]
//   cfg_inv    per-channel output inversion
//   cfg_en     per-channel enable (disabled channel drives 0)
//   cfg_stb    one-cycle strobe capturing all cfg_* into the shadow set
//   cfg_pend   shadow holds values not yet applied
//   upd_done   one-cycle pulse in the first cycle of a new active set
//   sync       one-cycle pulse on the first pwm cycle of each period
//   pwm        registered PWM outputs
module pwm_multi #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned N_CH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        cfg_period,
  input  logic [N_CH*WIDTH-1:0]   cfg_duty,
  input  logic [N_CH-1:0]         cfg_inv,
  input  logic [N_CH-1:0]         cfg_en,
  input  logic                    cfg_stb,
  output logic                    cfg_pend,
  output logic                    upd_done,
  output logic                    sync,
  output logic [N_CH-1:0]         pwm
);

  localparam int unsigned DUTY_W = N_CH * WIDTH;

  // Period counter
  logic [WIDTH-1:0]  cnt;

  // Active configuration
  logic [WIDTH-1:0]  per_a;
  logic [DUTY_W-1:0] duty_a;
  logic [N_CH-1:0]   inv_a;
  logic [N_CH-1:0]   en_a;

  // Shadow configuration
  logic [WIDTH-1:0]  per_s;
  logic [DUTY_W-1:0] duty_s;
  logic [N_CH-1:0]   inv_s;
  logic [N_CH-1:0]   en_s;

  logic              wrap_c;
  logic              apply_c;
  logic [N_CH-1:0]   pwm_nxt_c;

  // Last cycle of the active period; the only point where the active set may change
  assign wrap_c  = (cnt == per_a);
  assign apply_c = wrap_c & cfg_pend;

  // Free-running period counter, 0..per_a
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (wrap_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + WIDTH'(1);
    end
  end

  // Shadow set: last strobe wins, independent of the wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      per_s  <= '0;
      duty_s <= '0;
      inv_s  <= '0;
      en_s   <= '0;
    end else if (cfg_stb) begin
      per_s  <= cfg_period;
      duty_s <= cfg_duty;
      inv_s  <= cfg_inv;
      en_s   <= cfg_en;
    end
  end

  // Active set: takes the shadow contents as they stood before any
  // coinciding strobe, so a strobe in the wrap cycle lands one period later
  always_ff @(posedge clk) begin
    if (rst) begin
      per_a  <= '0;
      duty_a <= '0;
      inv_a  <= '0;
      en_a   <= '0;
    end else if (apply_c) begin
      per_a  <= per_s;
      duty_a <= duty_s;
      inv_a  <= inv_s;
      en_a   <= en_s;
    end
  end

  // Pending flag and update/sync pulses; a strobe always leaves pend set
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_pend <= 1'b0;
      upd_done <= 1'b0;
      sync     <= 1'b0;
    end else begin
      if (cfg_stb) begin
        cfg_pend <= 1'b1;
      end else if (apply_c) begin
        cfg_pend <= 1'b0;
      end
      upd_done <= apply_c;
      sync     <= (cnt == '0);
    end
  end

  // Per-channel compare; unsigned compare saturates high when duty > period
  for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
    logic [WIDTH-1:0] duty_i;
    assign duty_i       = duty_a[i*WIDTH +: WIDTH];
    assign pwm_nxt_c[i] = en_a[i] & ((cnt < duty_i) ^ inv_a[i]);
  end

  // Output register
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm <= '0;
    end else begin
      pwm <= pwm_nxt_c;
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Directed self-checking bench for pwm_multi (WIDTH=8, N_CH=2).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_pwm_multi;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned N_CH  = 2;

  logic                  clk;
  logic                  rst;
  logic [WIDTH-1:0]      cfg_period;
  logic [N_CH*WIDTH-1:0] cfg_duty;
  logic [N_CH-1:0]       cfg_inv;
  logic [N_CH-1:0]       cfg_en;
  logic                  cfg_stb;
  logic                  cfg_pend;
  logic                  upd_done;
  logic                  sync;
  logic [N_CH-1:0]       pwm;

  int checks = 0;
  int passed = 0;

  pwm_multi #(.WIDTH(WIDTH), .N_CH(N_CH)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_period (cfg_period),
    .cfg_duty   (cfg_duty),
    .cfg_inv    (cfg_inv),
    .cfg_en     (cfg_en),
    .cfg_stb    (cfg_stb),
    .cfg_pend   (cfg_pend),
    .upd_done   (upd_done),
    .sync       (sync),
    .pwm        (pwm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick;
    @(negedge clk);
  endtask

  // Reset, strobe a configuration, and stop at the first sync cycle of it
  task automatic setup(input logic [7:0] p, input logic [7:0] d0, input logic [7:0] d1,
                       input logic [1:0] en, input logic [1:0] inv);
    cfg_stb = 1'b0;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    cfg_period = p;
    cfg_duty = {d1, d0};
    cfg_en = en;
    cfg_inv = inv;
    cfg_stb = 1'b1;
    tick;
    cfg_stb = 1'b0;
    tick;
    tick;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cfg_stb = 1'b0;
    tick;
    tick;
    checks++; if (pwm !== 2'b00) $display("FAIL reset_pwm got %b want 00", pwm); else passed++;
    checks++; if (sync !== 1'b0) $display("FAIL reset_sync got %b want 0", sync); else passed++;
    checks++; if (upd_done !== 1'b0) $display("FAIL reset_upd got %b want 0", upd_done); else passed++;
    checks++; if (cfg_pend !== 1'b0) $display("FAIL reset_pend got %b want 0", cfg_pend); else passed++;
  endtask

  task automatic test_basic;
    logic [1:0] exp_pwm;
    int k;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    cfg_period = 8'd9;
    cfg_duty = {8'd7, 8'd3};
    cfg_en = 2'b11;
    cfg_inv = 2'b00;
    cfg_stb = 1'b1;
    tick;
    cfg_stb = 1'b0;
    checks++; if (cfg_pend !== 1'b1) $display("FAIL basic_pend_rise got %b want 1", cfg_pend); else passed++;
    checks++; if (upd_done !== 1'b0) $display("FAIL basic_upd_early got %b want 0", upd_done); else passed++;
    checks++; if (pwm !== 2'b00) $display("FAIL basic_pwm_idle got %b want 00", pwm); else passed++;
    tick;
    checks++; if (upd_done !== 1'b1) $display("FAIL basic_upd got %b want 1", upd_done); else passed++;
    checks++; if (cfg_pend !== 1'b0) $display("FAIL basic_pend_fall got %b want 0", cfg_pend); else passed++;
    tick;
    for (int c = 0; c < 20; c++) begin
      k = c % 10;
      exp_pwm = {(k < 7), (k < 3)};
      checks++; if (pwm !== exp_pwm) $display("FAIL basic_pwm c=%0d got %b want %b", c, pwm, exp_pwm); else passed++;
      checks++; if (sync !== (k == 0)) $display("FAIL basic_sync c=%0d got %b want %b", c, sync, (k == 0)); else passed++;
      checks++; if (upd_done !== 1'b0) $display("FAIL basic_upd_steady c=%0d got %b want 0", c, upd_done); else passed++;
      tick;
    end
  endtask

  task automatic test_boundary;
    logic [1:0] exp_pwm;
    for (int t = 0; t < 3; t++) begin
      case (t)
        0: begin setup(8'd9, 8'd0,   8'd10, 2'b11, 2'b00); exp_pwm = 2'b10; end
        1: begin setup(8'd9, 8'd255, 8'd0,  2'b11, 2'b10); exp_pwm = 2'b11; end
        default: begin setup(8'd9, 8'd5, 8'd5, 2'b00, 2'b11); exp_pwm = 2'b00; end
      endcase
      for (int c = 0; c < 10; c++) begin
        checks++; if (pwm !== exp_pwm) $display("FAIL bound_pwm t=%0d c=%0d got %b want %b", t, c, pwm, exp_pwm); else passed++;
        checks++; if (sync !== (c == 0)) $display("FAIL bound_sync t=%0d c=%0d got %b want %b", t, c, sync, (c == 0)); else passed++;
        tick;
      end
    end
  endtask

  task automatic test_mid_update;
    logic [1:0] exp_pwm;
    logic exp_pend;
    int k;
    int d0;
    setup(8'd9, 8'd3, 8'd7, 2'b11, 2'b00);
    for (int c = 0; c < 20; c++) begin
      k = c % 10;
      d0 = (c < 10) ? 3 : 5;
      exp_pwm = {(k < 7), (k < d0)};
      exp_pend = (c >= 4) && (c <= 8);
      checks++; if (pwm !== exp_pwm) $display("FAIL mid_pwm c=%0d got %b want %b", c, pwm, exp_pwm); else passed++;
      checks++; if (cfg_pend !== exp_pend) $display("FAIL mid_pend c=%0d got %b want %b", c, cfg_pend, exp_pend); else passed++;
      checks++; if (upd_done !== (c == 9)) $display("FAIL mid_upd c=%0d got %b want %b", c, upd_done, (c == 9)); else passed++;
      checks++; if (sync !== (k == 0)) $display("FAIL mid_sync c=%0d got %b want %b", c, sync, (k == 0)); else passed++;
      if (c == 3) begin
        cfg_duty = {8'd7, 8'd5};
        cfg_stb = 1'b1;
      end else begin
        cfg_stb = 1'b0;
      end
      tick;
    end
  endtask

  task automatic test_collision;
    logic [1:0] exp_pwm;
    logic exp_pend;
    logic exp_upd;
    int k;
    int d0;
    setup(8'd9, 8'd3, 8'd7, 2'b11, 2'b00);
    for (int c = 0; c < 30; c++) begin
      k = c % 10;
      d0 = (c < 10) ? 3 : ((c < 20) ? 5 : 1);
      exp_pwm = {(k < 7), (k < d0)};
      exp_pend = (c >= 4) && (c <= 18);
      exp_upd = (c == 9) || (c == 19);
      checks++; if (pwm !== exp_pwm) $display("FAIL coll_pwm c=%0d got %b want %b", c, pwm, exp_pwm); else passed++;
      checks++; if (cfg_pend !== exp_pend) $display("FAIL coll_pend c=%0d got %b want %b", c, cfg_pend, exp_pend); else passed++;
      checks++; if (upd_done !== exp_upd) $display("FAIL coll_upd c=%0d got %b want %b", c, upd_done, exp_upd); else passed++;
      if (c == 3) begin
        cfg_duty = {8'd7, 8'd5};
        cfg_stb = 1'b1;
      end else if (c == 8) begin
        cfg_duty = {8'd7, 8'd1};
        cfg_stb = 1'b1;
      end else begin
        cfg_stb = 1'b0;
      end
      tick;
    end
  endtask

  task automatic test_period_change;
    logic [1:0] exp_pwm;
    int k;
    setup(8'd9, 8'd2, 8'd7, 2'b11, 2'b00);
    for (int c = 0; c < 22; c++) begin
      k = (c < 10) ? c : ((c - 10) % 4);
      exp_pwm = {(k < 7), (k < 2)};
      checks++; if (pwm !== exp_pwm) $display("FAIL per_pwm c=%0d got %b want %b", c, pwm, exp_pwm); else passed++;
      checks++; if (sync !== (k == 0)) $display("FAIL per_sync c=%0d got %b want %b", c, sync, (k == 0)); else passed++;
      checks++; if (upd_done !== (c == 9)) $display("FAIL per_upd c=%0d got %b want %b", c, upd_done, (c == 9)); else passed++;
      if (c == 3) begin
        cfg_period = 8'd3;
        cfg_stb = 1'b1;
      end else begin
        cfg_stb = 1'b0;
      end
      tick;
    end
  endtask

  task automatic test_reset_mid;
    logic [1:0] exp_pwm;
    int k;
    setup(8'd9, 8'd3, 8'd7, 2'b11, 2'b00);
    for (int c = 0; c < 5; c++) begin
      if (c == 3) begin
        cfg_period = 8'd5;
        cfg_duty = {8'd1, 8'd1};
        cfg_stb = 1'b1;
      end else begin
        cfg_stb = 1'b0;
      end
      tick;
    end
    checks++; if (cfg_pend !== 1'b1) $display("FAIL rmid_pend_before got %b want 1", cfg_pend); else passed++;
    rst = 1'b1;
    tick;
    checks++; if (pwm !== 2'b00) $display("FAIL rmid_pwm got %b want 00", pwm); else passed++;
    checks++; if (sync !== 1'b0) $display("FAIL rmid_sync got %b want 0", sync); else passed++;
    checks++; if (upd_done !== 1'b0) $display("FAIL rmid_upd got %b want 0", upd_done); else passed++;
    checks++; if (cfg_pend !== 1'b0) $display("FAIL rmid_pend got %b want 0", cfg_pend); else passed++;
    rst = 1'b0;
    tick;
    for (int c = 0; c < 10; c++) begin
      checks++; if (pwm !== 2'b00) $display("FAIL rmid_idle_pwm c=%0d got %b want 00", c, pwm); else passed++;
      checks++; if (upd_done !== 1'b0) $display("FAIL rmid_idle_upd c=%0d got %b want 0", c, upd_done); else passed++;
      checks++; if (cfg_pend !== 1'b0) $display("FAIL rmid_idle_pend c=%0d got %b want 0", c, cfg_pend); else passed++;
      checks++; if (sync !== 1'b1) $display("FAIL rmid_idle_sync c=%0d got %b want 1", c, sync); else passed++;
      tick;
    end
    cfg_period = 8'd4;
    cfg_duty = {8'd0, 8'd2};
    cfg_en = 2'b01;
    cfg_inv = 2'b00;
    cfg_stb = 1'b1;
    tick;
    cfg_stb = 1'b0;
    checks++; if (cfg_pend !== 1'b1) $display("FAIL rmid_new_pend got %b want 1", cfg_pend); else passed++;
    checks++; if (upd_done !== 1'b0) $display("FAIL rmid_new_upd_early got %b want 0", upd_done); else passed++;
    tick;
    checks++; if (upd_done !== 1'b1) $display("FAIL rmid_new_upd got %b want 1", upd_done); else passed++;
    checks++; if (cfg_pend !== 1'b0) $display("FAIL rmid_new_pend_fall got %b want 0", cfg_pend); else passed++;
    tick;
    for (int c = 0; c < 10; c++) begin
      k = c % 5;
      exp_pwm = {1'b0, (k < 2)};
      checks++; if (pwm !== exp_pwm) $display("FAIL rmid_new_pwm c=%0d got %b want %b", c, pwm, exp_pwm); else passed++;
      checks++; if (sync !== (k == 0)) $display("FAIL rmid_new_sync c=%0d got %b want %b", c, sync, (k == 0)); else passed++;
      tick;
    end
  endtask

  initial begin
    rst = 1'b1;
    cfg_period = '0;
    cfg_duty = '0;
    cfg_inv = '0;
    cfg_en = '0;
    cfg_stb = 1'b0;
    test_reset;
    test_basic;
    test_boundary;
    test_mid_update;
    test_collision;
    test_period_change;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
